// File: rtl/light_mode_ctrl_pkg.sv
// Shared light-bar definitions: FSM state encoding, mode codes and the
// state-to-output decode used by the mode controller and pattern generators.
package light_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_GAP = 3'd1,
    ST_P1  = 3'd2,
    ST_P2  = 3'd3,
    ST_P3  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_P1  = 2'd1;
  localparam logic [1:0] MODE_P2  = 2'd2;
  localparam logic [1:0] MODE_P3  = 2'd3;

  function automatic logic [1:0] state_mode(input state_e s);
    logic [1:0] m;
    m = MODE_OFF;
    unique case (s)
      ST_P1:   m = MODE_P1;
      ST_P2:   m = MODE_P2;
      ST_P3:   m = MODE_P3;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] state_enables(input state_e s);
    logic [2:0] en;
    en = '0;
    unique case (s)
      ST_P1:   en = 3'b001;
      ST_P2:   en = 3'b010;
      ST_P3:   en = 3'b100;
      default: en = '0;
    endcase
    return en;
  endfunction

  // Pattern entered after the gap that follows a next-press; OFF always targets P1.
  function automatic state_e next_pattern(input state_e s);
    state_e t;
    t = ST_P1;
    unique case (s)
      ST_P1:   t = ST_P2;
      ST_P2:   t = ST_P3;
      default: t = ST_P1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/light_mode_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-cycle debouncer
// and a one-cycle press pulse on each debounced rising transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      // Pulse is taken from the registered level so it lands DEBOUNCE_CYCLES+3 edges after the raw edge.
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/light_mode_ctrl.sv
// Light-bar mode controller: cycles through three patterns on next-press,
// separating every pair of active patterns with an all-off gap.
module light_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_off,
  output logic [2:0] pattern_en,
  output logic [1:0] mode,
  output logic       busy
);

  import light_mode_ctrl_pkg::*;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic       next_press, off_press;
  state_e     state_q, state_d;
  state_e     target_q, target_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [2:0] pattern_en_q;
  logic [1:0] mode_q;
  logic       busy_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_next),
    .press_o (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_off (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_off),
    .press_o (off_press)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    gap_cnt_d = gap_cnt_q;
    if (off_press) begin
      state_d   = ST_OFF;
      target_d  = ST_P1;
      gap_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: if (next_press) begin
          state_d   = ST_GAP;
          target_d  = ST_P1;
          gap_cnt_d = '0;
        end
        ST_GAP: if (gap_cnt_q == GAP_LAST) begin
          state_d   = target_q;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
        ST_P1, ST_P2, ST_P3: if (next_press) begin
          state_d   = ST_GAP;
          target_d  = next_pattern(state_q);
          gap_cnt_d = '0;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_OFF;
      target_q     <= ST_P1;
      gap_cnt_q    <= '0;
      pattern_en_q <= '0;
      mode_q       <= MODE_OFF;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      gap_cnt_q    <= gap_cnt_d;
      pattern_en_q <= state_enables(state_d);
      mode_q       <= state_mode(state_d);
      busy_q       <= (state_d == ST_GAP);
    end
  end

  assign pattern_en = pattern_en_q;
  assign mode       = mode_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Self-checking bench for light_mode_ctrl: a run-length debounce model plus a
// mode/gap model checked every cycle, and directed scenarios with literal checks.
module tb_light_mode_ctrl;

  localparam int DEB = 4;
  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       reset, btn_next, btn_off;
  logic [2:0] pattern_en;
  logic [1:0] mode;
  logic       busy;

  light_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
    .clock      (clk),
    .reset      (reset),
    .btn_next   (btn_next),
    .btn_off    (btn_off),
    .pattern_en (pattern_en),
    .mode       (mode),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit model_valid = 1'b0;
  bit raw_now [2];
  bit rd0 [2];
  bit rd1 [2];
  bit win [2][DEB];
  bit dl  [2];
  bit dlo [2];
  bit pq  [2];
  bit pnew, dsamp, all_diff;
  int m_mode, m_left, m_tgt;
  bit m_gap;

  always @(posedge clk) begin
    raw_now[0] = btn_next;
    raw_now[1] = btn_off;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        rd0[b] = 0; rd1[b] = 0; dl[b] = 0; dlo[b] = 0; pq[b] = 0;
        for (int k = 0; k < DEB; k++) win[b][k] = 0;
      end
      m_mode = 0; m_gap = 0; m_left = 0; m_tgt = 1;
      model_valid = 1'b1;
    end else begin
      // mode machine reacts to the presses registered on the previous edge
      if (pq[1]) begin
        m_mode = 0; m_gap = 0; m_tgt = 1;
      end else if (m_gap) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_gap  = 0;
          m_mode = m_tgt;
        end
      end else if (pq[0]) begin
        m_tgt  = (m_mode == 0) ? 1 : (m_mode % 3) + 1;
        m_gap  = 1;
        m_left = GAP;
        m_mode = 0;
      end
      for (int b = 0; b < 2; b++) begin
        pnew   = dl[b] && !dlo[b];
        dlo[b] = dl[b];
        dsamp  = rd1[b];
        rd1[b] = rd0[b];
        rd0[b] = raw_now[b];
        for (int k = DEB - 1; k > 0; k--) win[b][k] = win[b][k-1];
        win[b][0] = dsamp;
        all_diff = 1;
        for (int k = 0; k < DEB; k++) if (win[b][k] == dl[b]) all_diff = 0;
        if (all_diff) dl[b] = !dl[b];
        pq[b] = pnew;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int last_high [3] = '{-1000, -1000, -1000};
  bit saw_p3 = 1'b0;
  bit sep_ok;

  always @(negedge clk) begin
    if (model_valid) begin
      cyc++;
      check("model_en",   pattern_en, (m_mode == 0) ? 0 : (1 << (m_mode - 1)));
      check("model_mode", mode, m_mode);
      check("model_busy", busy, m_gap);
      check("onehot", ($countones(pattern_en) <= 1) ? 1 : 0, 1);
      sep_ok = 1;
      for (int i = 0; i < 3; i++)
        if (pattern_en[i])
          for (int j = 0; j < 3; j++)
            if (j != i && (cyc - last_high[j]) <= GAP) sep_ok = 0;
      check("enable_separation", sep_ok, 1);
      for (int i = 0; i < 3; i++) if (pattern_en[i]) last_high[i] = cyc;
      if (pattern_en[2]) saw_p3 = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    cycles(8);
    btn_next = 1'b0;
    cycles(14);
  endtask

  initial begin
    reset = 1'b1; btn_next = 1'b0; btn_off = 1'b0;
    cycles(3);
    check("rst_en", pattern_en, 0);
    check("rst_mode", mode, 0);
    check("rst_busy", busy, 0);

    // held button: pulse after edge 7, gap on edges 8..10, P1 from edge 11
    reset = 1'b0; btn_next = 1'b1;
    cycles(7);
    check("e7_busy", busy, 0);
    check("e7_mode", mode, 0);
    cycles(1);
    check("e8_busy", busy, 1);
    cycles(2);
    check("e10_busy", busy, 1);
    check("e10_en", pattern_en, 0);
    cycles(1);
    check("e11_en", pattern_en, 3'b001);
    check("e11_mode", mode, 1);
    check("e11_busy", busy, 0);
    cycles(9);
    check("held_mode", mode, 1);
    btn_next = 1'b0;
    cycles(12);

    press_next(); check("seq_p2", pattern_en, 3'b010);
    press_next(); check("seq_p3", pattern_en, 3'b100);
    press_next(); check("seq_wrap", pattern_en, 3'b001);

    // bouncing button never holds DEB cycles
    for (int i = 0; i < 15; i++) begin
      btn_next = ~btn_next;
      cycles(2);
    end
    btn_next = 1'b0;
    cycles(12);
    check("bounce_mode", mode, 1);

    // simultaneous next and off in P2
    press_next(); check("pre_both_mode", mode, 2);
    btn_next = 1'b1; btn_off = 1'b1;
    cycles(8);
    btn_next = 1'b0; btn_off = 1'b0;
    cycles(14);
    check("both_mode", mode, 0);
    check("both_en", pattern_en, 0);

    // off-press lands inside the gap heading to P3
    press_next(); press_next();
    check("pre_cancel_mode", mode, 2);
    saw_p3 = 1'b0;
    btn_next = 1'b1;
    cycles(2);
    btn_off = 1'b1;
    cycles(6);
    btn_next = 1'b0;
    cycles(2);
    btn_off = 1'b0;
    cycles(14);
    check("cancel_mode", mode, 0);
    check("cancel_no_p3", saw_p3, 0);

    // one-cycle reset in the middle of the gap heading to P2
    press_next(); check("pre_rst_mode", mode, 1);
    btn_next = 1'b1;
    cycles(6);
    btn_next = 1'b0;
    cycles(2);
    check("midgap_busy", busy, 1);
    reset = 1'b1;
    cycles(1);
    check("midrst_en", pattern_en, 0);
    check("midrst_mode", mode, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    cycles(14);
    check("post_rst_mode", mode, 0);
    press_next();
    check("post_rst_target", pattern_en, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
